// File: rtl/glitch_pulse_gen.sv
// Trigger-armed glitch-enable sequencer: after arm + trigger, waits `delay` cycles and emits `count` pulses.
// Optional: define GLITCH_RETRIGGER_EN so a finished run re-arms with the latched config instead of idling.
module glitch_pulse_gen #(
  parameter int DELAY_W = 16,
  parameter int WIDTH_W = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trigger,
  input  logic               arm,
  input  logic               abort,
  input  logic [DELAY_W-1:0] delay,
  input  logic [WIDTH_W-1:0] width,
  input  logic [WIDTH_W-1:0] gap,
  input  logic [COUNT_W-1:0] count,
  input  logic [3:0]         mode_in,
  output logic               en,
  output logic [3:0]         mode_out,
  output logic               busy,
  output logic               done
);
  localparam int CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DELAY, S_PULSE, S_GAP} state_e;

`ifdef GLITCH_RETRIGGER_EN
  localparam state_e RUN_END = S_ARMED;
`else
  localparam state_e RUN_END = S_IDLE;
`endif

  state_e               state_q, state_d;
  logic                 en_q, en_d, done_q, done_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [COUNT_W-1:0]   pulses_q, pulses_d;
  logic [DELAY_W-1:0]   dly_cfg_q, dly_cfg_d;
  logic [WIDTH_W-1:0]   wid_cfg_q, wid_cfg_d, gap_cfg_q, gap_cfg_d;
  logic [COUNT_W-1:0]   num_cfg_q, num_cfg_d;
  logic [3:0]           mode_q, mode_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic                 trig_rise;
  logic [CNT_W-1:0]     wid_ld, gap_ld, dly_ld;

  assign trig_rise = sync2_q & ~prev_q;
  // Counters run down to zero, so a phase of N cycles loads N-1.
  assign wid_ld = CNT_W'(wid_cfg_q - WIDTH_W'(1));
  assign gap_ld = CNT_W'(gap_cfg_q - WIDTH_W'(1));
  assign dly_ld = CNT_W'(dly_cfg_q - DELAY_W'(1));

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    pulses_d  = pulses_q;
    dly_cfg_d = dly_cfg_q;
    wid_cfg_d = wid_cfg_q;
    gap_cfg_d = gap_cfg_q;
    num_cfg_d = num_cfg_q;
    mode_d    = mode_q;
    if (abort) begin
      state_d  = S_IDLE;
      en_d     = 1'b0;
      cnt_d    = '0;
      pulses_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (arm) begin
          dly_cfg_d = delay;
          wid_cfg_d = (width == '0) ? WIDTH_W'(1) : width;
          gap_cfg_d = (gap   == '0) ? WIDTH_W'(1) : gap;
          num_cfg_d = (count == '0) ? COUNT_W'(1) : count;
          mode_d    = mode_in;
          state_d   = S_ARMED;
        end
        S_ARMED: if (trig_rise) begin
          pulses_d = num_cfg_q;
          if (dly_cfg_q == '0) begin
            state_d = S_PULSE;
            en_d    = 1'b1;
            cnt_d   = wid_ld;
          end else begin
            state_d = S_DELAY;
            cnt_d   = dly_ld;
          end
        end
        S_DELAY, S_GAP: begin
          if (cnt_q == '0) begin
            state_d = S_PULSE;
            en_d    = 1'b1;
            cnt_d   = wid_ld;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            en_d     = 1'b0;
            pulses_d = pulses_q - COUNT_W'(1);
            if (pulses_q == COUNT_W'(1)) begin
              state_d = RUN_END;
              done_d  = 1'b1;
            end else begin
              state_d = S_GAP;
              cnt_d   = gap_ld;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      pulses_q  <= '0;
      dly_cfg_q <= '0;
      wid_cfg_q <= '0;
      gap_cfg_q <= '0;
      num_cfg_q <= '0;
      mode_q    <= 4'b0000;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      pulses_q  <= pulses_d;
      dly_cfg_q <= dly_cfg_d;
      wid_cfg_q <= wid_cfg_d;
      gap_cfg_q <= gap_cfg_d;
      num_cfg_q <= num_cfg_d;
      mode_q    <= mode_d;
      sync1_q   <= trigger;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
    end
  end

  assign en       = en_q;
  assign done     = done_q;
  assign mode_out = mode_q;
  assign busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Randomized + directed bench for glitch_pulse_gen against a run-offset reference model.
// Build with GLITCH_RETRIGGER_EN defined to cover the re-arm variant.
module tb_glitch_pulse_gen;
  localparam int DW = 16, WW = 8, CW = 8;

  logic          clk = 1'b0, rst_n = 1'b0, trigger = 1'b0, arm = 1'b0, abort = 1'b0;
  logic [DW-1:0] delay = '0;
  logic [WW-1:0] width = '0, gap = '0;
  logic [CW-1:0] count = '0;
  logic [3:0]    mode_in = '0, mode_out;
  logic          en, busy, done;

  int n_cmp = 0, n_bad = 0;
  int en_cnt = 0, done_cnt = 0;

  // Reference model: 0 idle, 1 armed, 2 running (m_k edges since the accepting edge)
  int       m_state, m_k, m_len, m_dly, m_w, m_g, m_c;
  logic [3:0] m_mode;
  bit       m_done, h1, h2, h3;

  glitch_pulse_gen #(.DELAY_W(DW), .WIDTH_W(WW), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .arm(arm), .abort(abort),
    .delay(delay), .width(width), .gap(gap), .count(count), .mode_in(mode_in),
    .en(en), .mode_out(mode_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_en();
    int t;
    if (m_state != 2 || m_k < m_dly) return 1'b0;
    t = m_k - m_dly;
    return (t / (m_w + m_g) < m_c) && (t % (m_w + m_g) < m_w);
  endfunction

  task automatic model_reset();
    m_state = 0; m_k = 0; m_len = 0; m_mode = 4'b0000; m_done = 1'b0;
    m_dly = 0; m_w = 1; m_g = 1; m_c = 1;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
  endtask

  task automatic model_edge();
    bit rise;
    rise   = h2 & ~h3;
    m_done = 1'b0;
    if (abort) m_state = 0;
    else case (m_state)
      0: if (arm) begin
        m_dly  = int'(delay);
        m_w    = (width == 0) ? 1 : int'(width);
        m_g    = (gap   == 0) ? 1 : int'(gap);
        m_c    = (count == 0) ? 1 : int'(count);
        m_mode = mode_in;
        m_len  = m_dly + m_c * m_w + (m_c - 1) * m_g;
        m_state = 1;
      end
      1: if (rise) begin m_state = 2; m_k = 0; end
      default: begin
        m_k++;
        if (m_k == m_len) begin
          m_done = 1'b1;
`ifdef GLITCH_RETRIGGER_EN
          m_state = 1;
`else
          m_state = 0;
`endif
        end
      end
    endcase
    h3 = h2; h2 = h1; h1 = trigger;
  endtask

  task automatic check_outputs();
    chk("en", 32'(en), 32'(exp_en()));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("mode_out", 32'(mode_out), 32'(m_mode));
    en_cnt   += int'(en);
    done_cnt += int'(done);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic cfg_arm(input int d, input int w, input int g, input int c, input logic [3:0] m);
    delay = DW'(d); width = WW'(w); gap = WW'(g); count = CW'(c); mode_in = m;
    arm = 1'b1; step(); arm = 1'b0;
    mode_in = ~m;  // latched mode must not follow the input after arm
  endtask

  task automatic do_abort();
    abort = 1'b1; step(); abort = 1'b0;
    trigger = 1'b0; run(4);
  endtask

  initial begin
    bit seen;
    model_reset();
    do_reset();
    run(2);

    // Basic two-pulse burst
    cfg_arm(5, 3, 2, 2, 4'b0100);
    en_cnt = 0; done_cnt = 0;
    trigger = 1'b1; run(30);
    chk("t1_en_cycles", 32'(en_cnt), 32'd6);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_mode", 32'(mode_out), 32'h4);
    do_abort();

    // Zero delay/width/count -> single 1-cycle pulse
    cfg_arm(0, 0, 5, 0, 4'hA);
    en_cnt = 0; done_cnt = 0;
    trigger = 1'b1; run(8);
    chk("t2_en_cycles", 32'(en_cnt), 32'd1);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    do_abort();

    // Trigger before arm is ignored
    trigger = 1'b1; run(3); trigger = 1'b0; run(3);
    cfg_arm(1, 2, 1, 1, 4'h3);
    en_cnt = 0; run(8);
    chk("t3_en_cycles", 32'(en_cnt), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    do_abort();

    // Abort in 2nd cycle of a 10-wide pulse
    cfg_arm(0, 10, 1, 1, 4'h6);
    done_cnt = 0; seen = 1'b0;
    trigger = 1'b1;
    for (int i = 0; i < 12 && !seen; i++) begin step(); seen = en; end
    chk("t4_en_seen", 32'(seen), 32'd1);
    step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("t4_en_after_abort", 32'(en), 32'd0);
    chk("t4_busy_after_abort", 32'(busy), 32'd0);
    trigger = 1'b0; run(3); trigger = 1'b1; en_cnt = 0; run(8);
    chk("t4_en_ignored", 32'(en_cnt), 32'd0);
    chk("t4_no_done", 32'(done_cnt), 32'd0);
    chk("t4_mode_kept", 32'(mode_out), 32'h6);
    trigger = 1'b0; run(3);

    // Reset mid-gap, then a clean run
    cfg_arm(0, 3, 6, 3, 4'h9);
    trigger = 1'b1; run(6);
    do_reset();
    chk("t5_en_rst", 32'(en), 32'd0);
    chk("t5_mode_rst", 32'(mode_out), 32'd0);
    trigger = 1'b0; run(4);
    cfg_arm(2, 2, 1, 2, 4'h3);
    done_cnt = 0; en_cnt = 0;
    trigger = 1'b1; run(20);
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);
    chk("t5_en_cycles", 32'(en_cnt), 32'd4);
    do_abort();

`ifdef GLITCH_RETRIGGER_EN
    cfg_arm(0, 2, 0, 1, 4'h5);
    done_cnt = 0;
    trigger = 1'b1; run(6); trigger = 1'b0; run(3);
    chk("t6_busy_between", 32'(busy), 32'd1);
    trigger = 1'b1; run(6);
    chk("t6_done_cnt", 32'(done_cnt), 32'd2);
    do_abort();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      arm     = ($urandom_range(7) == 0);
      abort   = ($urandom_range(60) == 0);
      if ($urandom_range(5) == 0) trigger = ~trigger;
      delay   = DW'($urandom_range(6));
      width   = WW'($urandom_range(4));
      gap     = WW'($urandom_range(3));
      count   = CW'($urandom_range(3));
      mode_in = 4'($urandom);
      if ($urandom_range(700) == 0) do_reset(); else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
